rst_seq_gen: RTL and testbench



---
 rtl/rst_seq_pkg.sv | 29 ++
 rtl/rst_sync_chain.sv | 30 +++
 rtl/rst_seq_gen.sv | 138 +++++++++++++
 tb/tb_rst_seq_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_pkg
// Description : Shared types and helpers for the reset sequencer: FSM state
//               encoding, counter width helper, parameter legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package rst_seq_pkg;

    // Encoding is visible on the state output port, so values are fixed.
    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    // Width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_legal(input int sync_stages, input int stretch,
                                        input int nout, input int gap);
        return (sync_stages >= 2) && (stretch >= 1) && (nout >= 1) && (gap >= 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rst_sync_chain.sv
`default_nettype none
// ============================================================================
// Module      : rst_sync_chain
// Description : Reset deassertion synchronizer. Asynchronous clear, synchronous
//               release after SYNC_STAGES rising edges.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rn,
    output logic rn_sync
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift a constant one through the chain; RN low clears it at once.
    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rn_sync = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rst_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_gen
// Description : Reset synchronizer and sequencer. Stretches a synchronized
//               reset release, then releases NOUT reset domains in order,
//               GAP cycles apart. Software request re-runs the sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 16,
    parameter int NOUT        = 4,
    parameter int GAP         = 4
) (
    input  logic            CLK,
    input  logic            RN,
    input  logic            sw_rst_req,
    input  logic            ext_hold,
    output logic [NOUT-1:0] rn_out,
    output logic            rst_done,
    output logic [1:0]      state
);

    localparam int CNT_W  = cnt_width(STRETCH);
    localparam int GCNT_W = cnt_width(GAP);
    localparam int IDX_W  = cnt_width(NOUT);

    if (!params_legal(SYNC_STAGES, STRETCH, NOUT, GAP)) begin : g_param_check
        $error("rst_seq_gen: illegal parameter set");
    end

    logic              rn_sync;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NOUT-1:0]   rn_out_d;
    logic              rst_done_d;

    rst_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (CLK),
        .rn      (RN),
        .rn_sync (rn_sync)
    );

    // State, counters and reset outputs all live in flops cleared by RN, so
    // every rn_out bit is a direct flop output and cannot glitch.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q  <= ST_ASSERT;
            cnt_q    <= '0;
            gcnt_q   <= '0;
            idx_q    <= '0;
            rn_out   <= '0;
            rst_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gcnt_q   <= gcnt_d;
            idx_q    <= idx_d;
            rn_out   <= rn_out_d;
            rst_done <= rst_done_d;
        end
    end

    // Next-state logic: ext_hold freezes the counters, software request
    // overrides everything except the asynchronous reset.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gcnt_d     = gcnt_q;
        idx_d      = idx_q;
        rn_out_d   = rn_out;
        rst_done_d = rst_done;

        case (state_q)
            ST_ASSERT: begin
                if (rn_sync && !ext_hold) begin
                    state_d = ST_STRETCH;
                    cnt_d   = '0;
                end
            end
            ST_STRETCH: begin
                if (!ext_hold) begin
                    if (cnt_q == CNT_W'(STRETCH - 1)) begin
                        rn_out_d = NOUT'(1);
                        idx_d    = IDX_W'(1);
                        gcnt_d   = '0;
                        if (NOUT == 1) begin
                            state_d    = ST_RUN;
                            rst_done_d = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                if (!ext_hold) begin
                    if (gcnt_q == GCNT_W'(GAP - 1)) begin
                        // Outputs form a thermometer code, so the next
                        // domain is released by shifting in another one.
                        rn_out_d = (rn_out << 1) | NOUT'(1);
                        gcnt_d   = '0;
                        if (idx_q == IDX_W'(NOUT - 1)) begin
                            state_d    = ST_RUN;
                            rst_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        gcnt_d = gcnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (sw_rst_req && (state_q != ST_ASSERT)) begin
            state_d    = ST_STRETCH;
            cnt_d      = '0;
            gcnt_d     = '0;
            idx_d      = '0;
            rn_out_d   = '0;
            rst_done_d = 1'b0;
        end
    end

    assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_rst_seq_gen
// Description : Self-checking bench for rst_seq_gen (default parameters plus a
//               minimal NOUT=1 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_seq_gen;

    localparam int SYN = 2;
    localparam int STR = 16;
    localparam int NO  = 4;
    localparam int GP  = 4;

    logic       CLK;
    logic       RN, sw_rst_req, ext_hold;
    logic [3:0] rn_out;
    logic       rst_done;
    logic [1:0] state;

    logic       RN1, sw1, hold1;
    logic [0:0] rn_out1;
    logic       rst_done1;
    logic [1:0] state1;

    int n_checks = 0;
    int n_pass   = 0;

    rst_seq_gen #(.SYNC_STAGES(SYN), .STRETCH(STR), .NOUT(NO), .GAP(GP)) dut (
        .CLK        (CLK),
        .RN         (RN),
        .sw_rst_req (sw_rst_req),
        .ext_hold   (ext_hold),
        .rn_out     (rn_out),
        .rst_done   (rst_done),
        .state      (state)
    );

    rst_seq_gen #(.SYNC_STAGES(2), .STRETCH(1), .NOUT(1), .GAP(1)) dut1 (
        .CLK        (CLK),
        .RN         (RN1),
        .sw_rst_req (sw1),
        .ext_hold   (hold1),
        .rn_out     (rn_out1),
        .rst_done   (rst_done1),
        .state      (state1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int         n;
        bit         sw;
        bit         hold;
        logic [3:0] out;
        logic       done;
        logic [1:0] st;
        string      name;
    } vec_t;

    vec_t tab[$];

    task automatic chk(input string name, input logic [3:0] o, input logic d, input logic [1:0] s,
                       input logic [3:0] eo, input logic ed, input logic [1:0] es);
        n_checks++;
        if (o === eo && d === ed && s === es) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got rn_out=%b rst_done=%b state=%0d, want rn_out=%b rst_done=%b state=%0d",
                     name, o, d, s, eo, ed, es);
        end
    endtask

    task automatic add(input int n, input bit sw, input bit hold, input logic [3:0] out,
                       input logic done, input logic [1:0] st, input string name);
        vec_t v;
        v.n = n; v.sw = sw; v.hold = hold; v.out = out; v.done = done; v.st = st; v.name = name;
        tab.push_back(v);
    endtask

    // Each record: drive inputs, let n edges pass, then compare just after the edge.
    task automatic run_tab();
        foreach (tab[i]) begin
            sw_rst_req = tab[i].sw;
            ext_hold   = tab[i].hold;
            repeat (tab[i].n) @(posedge CLK);
            #1;
            chk(tab[i].name, rn_out, rst_done, state, tab[i].out, tab[i].done, tab[i].st);
        end
        tab.delete();
        sw_rst_req = 1'b0;
        ext_hold   = 1'b0;
    endtask

    // Asynchronous RN pulse placed mid-cycle; outputs must clear before any edge.
    task automatic rn_pulse(input string name);
        #2 RN = 1'b0;
        #1 chk(name, rn_out, rst_done, state, 4'b0000, 1'b0, 2'd0);
        #1 RN = 1'b1;
    endtask

    // Reference model in terms of elapsed unheld cycles since the sequence started.
    int m_sync;
    bit m_started;
    int m_t;

    function automatic int m_rel();
        int r;
        if (!m_started || m_t < STR) return 0;
        r = 1 + (m_t - STR) / GP;
        return (r > NO) ? NO : r;
    endfunction

    task automatic m_reset();
        m_sync = 0; m_started = 1'b0; m_t = 0;
    endtask

    task automatic m_edge(input bit sw, input bit hold);
        if (!m_started) begin
            if (m_sync >= SYN && !hold) begin
                m_started = 1'b1;
                m_t = 0;
            end
        end else if (sw) begin
            m_t = 0;
        end else if (!hold && m_rel() < NO) begin
            m_t++;
        end
        if (m_sync < SYN) m_sync++;
    endtask

    task automatic m_check(input string name);
        int         r;
        logic [3:0] eo;
        logic [1:0] es;
        r  = m_rel();
        eo = 4'((1 << r) - 1);
        if (!m_started)  es = 2'd0;
        else if (r == 0) es = 2'd1;
        else if (r < NO) es = 2'd2;
        else             es = 2'd3;
        chk(name, rn_out, rst_done, state, eo, (r == NO), es);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    initial begin
        bit saw_release;
        RN = 1'b0; sw_rst_req = 1'b0; ext_hold = 1'b0;
        RN1 = 1'b0; sw1 = 1'b0; hold1 = 1'b0;

        // Outputs held cleared while RN is low.
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            chk("por_reset", rn_out, rst_done, state, 4'b0000, 1'b0, 2'd0);
        end

        // Minimal instance: ASSERT -> STRETCH -> RUN, release at edge 4.
        RN1 = 1'b1;
        saw_release = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            logic [3:0] eo;
            logic       ed;
            logic [1:0] es;
            @(posedge CLK); #1;
            eo = (e >= 4) ? 4'b0001 : 4'b0000;
            ed = (e >= 4);
            es = (e >= 4) ? 2'd3 : ((e == 3) ? 2'd1 : 2'd0);
            if (state1 == 2'd2) saw_release = 1'b1;
            chk($sformatf("nout1_edge%0d", e), {3'b000, rn_out1}, rst_done1, state1, eo, ed, es);
        end
        n_checks++;
        if (!saw_release) n_pass++;
        else $display("FAIL nout1_no_release: got state=2 observed, want never 2");

        // Power-up sequence, hold ignored in RUN, software request from RUN.
        RN = 1'b1;
        add(2,  0, 0, 4'b0000, 0, 2'd0, "pu_sync_wait");
        add(1,  0, 0, 4'b0000, 0, 2'd1, "pu_enter_stretch");
        add(15, 0, 0, 4'b0000, 0, 2'd1, "pu_edge18");
        add(1,  0, 0, 4'b0001, 0, 2'd2, "pu_edge19");
        add(3,  0, 0, 4'b0001, 0, 2'd2, "pu_edge22");
        add(1,  0, 0, 4'b0011, 0, 2'd2, "pu_edge23");
        add(4,  0, 0, 4'b0111, 0, 2'd2, "pu_edge27");
        add(3,  0, 0, 4'b0111, 0, 2'd2, "pu_edge30");
        add(1,  0, 0, 4'b1111, 1, 2'd3, "pu_edge31");
        add(5,  0, 1, 4'b1111, 1, 2'd3, "run_hold_ignored");
        add(1,  1, 0, 4'b0000, 0, 2'd1, "sw_edge_S");
        add(15, 0, 0, 4'b0000, 0, 2'd1, "sw_S15");
        add(1,  0, 0, 4'b0001, 0, 2'd2, "sw_S16");
        add(11, 0, 0, 4'b0111, 0, 2'd2, "sw_S27");
        add(1,  0, 0, 4'b1111, 1, 2'd3, "sw_S28");
        // Software request beats ext_hold in RELEASE; count stays at 0 while held.
        add(1,  1, 0, 4'b0000, 0, 2'd1, "sw2_restart");
        add(16, 0, 0, 4'b0001, 0, 2'd2, "sw2_in_release");
        add(3,  1, 1, 4'b0000, 0, 2'd1, "sw_and_hold");
        add(4,  0, 1, 4'b0000, 0, 2'd1, "hold_after_sw");
        add(15, 0, 0, 4'b0000, 0, 2'd1, "cnt_was_zero");
        add(1,  0, 0, 4'b0001, 0, 2'd2, "release_after_hold");
        add(4,  0, 0, 4'b0011, 0, 2'd2, "pre_rn_0011");
        run_tab();

        // Asynchronous RN mid-RELEASE, then full restart.
        rn_pulse("rn_async_mid_release");
        add(18, 0, 0, 4'b0000, 0, 2'd1, "restart_edge18");
        add(1,  0, 0, 4'b0001, 0, 2'd2, "restart_edge19");
        run_tab();

        // ext_hold for 5 edges at cnt=7 shifts every release by 5.
        rn_pulse("rn_async_mid_release2");
        add(2,  0, 0, 4'b0000, 0, 2'd0, "hs_sync_wait");
        add(8,  0, 0, 4'b0000, 0, 2'd1, "hs_cnt7");
        add(5,  0, 1, 4'b0000, 0, 2'd1, "hs_held");
        add(8,  0, 0, 4'b0000, 0, 2'd1, "hs_edge23");
        add(1,  0, 0, 4'b0001, 0, 2'd2, "hs_edge24");
        add(4,  0, 0, 4'b0011, 0, 2'd2, "hs_edge28");
        run_tab();

        // Randomized traffic against the reference model.
        #2 RN = 1'b0;
        m_reset();
        #1 RN = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(posedge CLK);
            m_edge(sw_rst_req, ext_hold);
            #1;
            m_check($sformatf("rand_cycle%0d", c));
            sw_rst_req = ($urandom_range(0, 39) == 0);
            ext_hold   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 RN = 1'b0;
                m_reset();
                #1 RN = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
